// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage.
// Holds the fetch FSM state encoding, the default reset PC and the NOP
// instruction used to fill an invalid IF/ID slot, plus a word-align helper.
package fetch_pkg;

    // Fetch FSM states:
    //   FETCH - request outstanding on pc, accept the response into IF/ID
    //   HOLD  - response captured while IF/ID was stalled, no request issued
    //   DROP  - redirected while a request was in flight; finish it, discard data
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } fetch_state_e;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;  // addi x0,x0,0

    // Instruction fetches are always word aligned; low two bits are forced to zero.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return addr & 32'hFFFF_FFFC;
    endfunction

endpackage

// File: rtl/fetch_if.sv
// Signal bundle between the fetch stage and its environment.
// Groups redirect/stall control from the pipeline, the instruction SRAM
// request/ack port and the registered IF/ID payload.
//   master : seen by fetch_unit (drives imem_req/addr, flush, if_*)
//   slave  : seen by the surrounding pipeline / SRAM model
interface fetch_if;
    // redirect and hazard control
    logic        pc_sel;
    logic [31:0] alu_target;
    logic        stall;
    // instruction SRAM port
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    // downstream
    logic        flush;
    logic        if_valid;
    logic [31:0] if_pc;
    logic [31:0] if_instr;

    modport master (
        input  pc_sel, alu_target, stall, imem_ack, imem_rdata,
        output imem_req, imem_addr, flush, if_valid, if_pc, if_instr
    );

    modport slave (
        output pc_sel, alu_target, stall, imem_ack, imem_rdata,
        input  imem_req, imem_addr, flush, if_valid, if_pc, if_instr
    );
endinterface

// File: rtl/fetch_unit.sv
// Instruction fetch stage: issues word reads to the instruction SRAM and fills the IF/ID register.
// Latency: IF/ID valid one cycle after imem_ack; one instruction per two cycles with a 1-cycle SRAM.
// Backpressure: stall freezes IF/ID; a response arriving under stall parks in a one-entry hold buffer.
//
// Ports:
//   clk, rst    single rising-edge clock, synchronous active-high reset
//   bus.pc_sel / bus.alu_target   taken branch/jump and its target (pc_sel wins over everything)
//   bus.stall                     hold IF/ID contents this cycle
//   bus.imem_req / imem_addr      SRAM read request; address held stable until imem_ack
//   bus.imem_ack / imem_rdata     SRAM response, data valid in the ack cycle
//   bus.flush                     combinational copy of pc_sel, kills ID/EX downstream
//   bus.if_valid / if_pc / if_instr   registered IF/ID payload (if_instr = NOP when invalid)
module fetch_unit #(
    parameter logic [31:0] RESET_PC  = fetch_pkg::RESET_PC_DEFAULT,
    parameter logic [31:0] NOP_INSTR = fetch_pkg::NOP_INSTR
) (
    input  logic         clk,
    input  logic         rst,
    fetch_if.master      bus
);
    import fetch_pkg::*;

    fetch_state_e state_q, state_d;

    // Address of the current (or next) fetch. In DROP it already holds the
    // redirect target while drop_addr_q keeps the in-flight address alive.
    logic [31:0] pc_q,         pc_d;
    logic [31:0] drop_addr_q,  drop_addr_d;

    // One-entry buffer for a response that arrived while IF/ID was stalled.
    logic [31:0] hold_pc_q,    hold_pc_d;
    logic [31:0] hold_instr_q, hold_instr_d;

    // IF/ID register
    logic        if_valid_q,   if_valid_d;
    logic [31:0] if_pc_q,      if_pc_d;
    logic [31:0] if_instr_q,   if_instr_d;

    logic [31:0] pc_plus4;
    logic [31:0] redirect_pc;

    // Natural 32-bit wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000.
    assign pc_plus4    = pc_q + 32'd4;
    assign redirect_pc = word_align(bus.alu_target);

    // ------------------------------------------------------------------
    // Next-state and datapath
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        drop_addr_d  = drop_addr_q;
        hold_pc_d    = hold_pc_q;
        hold_instr_d = hold_instr_q;
        if_valid_d   = if_valid_q;
        if_pc_d      = if_pc_q;
        if_instr_d   = if_instr_q;

        // Unless something below loads a new instruction, an unstalled IF/ID
        // slot turns into a bubble; if_pc keeps its last value.
        if (!bus.stall) begin
            if_valid_d = 1'b0;
            if_instr_d = NOP_INSTR;
        end

        if (bus.pc_sel) begin
            // Redirect overrides stall and ack: kill the slot, drop the hold
            // buffer and point pc at the target.
            if_valid_d   = 1'b0;
            if_instr_d   = NOP_INSTR;
            hold_pc_d    = '0;
            hold_instr_d = '0;
            pc_d         = redirect_pc;
            unique case (state_q)
                FETCH: begin
                    if (!bus.imem_ack) begin
                        // The SRAM still owes us data for the old address;
                        // keep asking for it so the handshake stays legal.
                        state_d     = DROP;
                        drop_addr_d = pc_q;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end else begin
            unique case (state_q)
                FETCH: begin
                    if (bus.imem_ack) begin
                        if (bus.stall) begin
                            hold_pc_d    = pc_q;
                            hold_instr_d = bus.imem_rdata;
                            state_d      = HOLD;
                        end else begin
                            if_valid_d = 1'b1;
                            if_pc_d    = pc_q;
                            if_instr_d = bus.imem_rdata;
                            pc_d       = pc_plus4;
                        end
                    end
                end
                HOLD: begin
                    // pc still equals hold_pc_q here; it advances on release.
                    if (!bus.stall) begin
                        if_valid_d = 1'b1;
                        if_pc_d    = hold_pc_q;
                        if_instr_d = hold_instr_q;
                        pc_d       = pc_plus4;
                        state_d    = FETCH;
                    end
                end
                DROP: begin
                    if (bus.imem_ack) begin
                        state_d = FETCH;
                    end
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // State registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= FETCH;
            pc_q         <= RESET_PC;
            drop_addr_q  <= '0;
            hold_pc_q    <= '0;
            hold_instr_q <= '0;
            if_valid_q   <= 1'b0;
            if_pc_q      <= '0;
            if_instr_q   <= NOP_INSTR;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            drop_addr_q  <= drop_addr_d;
            hold_pc_q    <= hold_pc_d;
            hold_instr_q <= hold_instr_d;
            if_valid_q   <= if_valid_d;
            if_pc_q      <= if_pc_d;
            if_instr_q   <= if_instr_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    // No request while parked in HOLD, and any in-flight request is abandoned
    // during reset.
    assign bus.imem_req  = !rst && (state_q != HOLD);
    assign bus.imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    assign bus.flush     = bus.pc_sel;

    assign bus.if_valid  = if_valid_q;
    assign bus.if_pc     = if_pc_q;
    assign bus.if_instr  = if_instr_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomized bench for fetch_unit with an SRAM responder, a transaction-level
// reference model and a scoreboard monitor on the IF/ID outputs.
module tb_fetch_unit;

    localparam logic [31:0] XOR_KEY  = 32'hA5A5_A5A5;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] RST_PC_A = 32'h0000_0000;
    localparam logic [31:0] RST_PC_B = 32'hFFFF_FFFC;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } item_t;

    logic clk = 1'b0;
    logic rst;
    logic rst2;
    always #5 clk = ~clk;

    fetch_if bus  ();
    fetch_if bus2 ();

    fetch_unit dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    fetch_unit #(.RESET_PC(RST_PC_B)) dut2 (
        .clk (clk),
        .rst (rst2),
        .bus (bus2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
        end
    endtask

    // ---------------- reference model state ----------------
    // Architectural view: next address to fetch, the one request the SRAM
    // owes us, whether that request has been made obsolete by a redirect,
    // and an instruction parked because IF/ID was stalled.
    item_t       exp_q[$];
    logic [31:0] model_pc    = RST_PC_A;
    bit          outstanding = 0;
    logic [31:0] out_addr    = '0;
    bit          dropped     = 0;
    int          age         = 0;
    int          lat         = 1;
    int          force_lat   = -1;
    bit          hold_valid  = 0;
    item_t       hold_item;

    // One clock cycle: starts and ends 1 time unit after a rising edge.
    task automatic do_cycle(input logic r, input logic s, input logic p, input logic [31:0] tgt);
        logic        ack;
        logic [31:0] rdata;
        item_t       it;
        rst            = r;
        bus.stall      = s;
        bus.pc_sel     = p;
        bus.alu_target = tgt;
        bus.imem_ack   = 1'b0;
        bus.imem_rdata = $urandom;
        #1;
        ack   = 1'b0;
        rdata = bus.imem_rdata;
        if (r) begin
            check("req_in_reset", {31'd0, bus.imem_req}, 32'd0);
            // An ack that happens to land in the reset cycle must be ignored.
            if (outstanding && age >= lat) begin
                ack   = 1'b1;
                rdata = out_addr ^ XOR_KEY;
            end
        end else if (hold_valid) begin
            check("req_in_hold", {31'd0, bus.imem_req}, 32'd0);
        end else begin
            check("req_active", {31'd0, bus.imem_req}, 32'd1);
            if (!outstanding) begin
                check("new_req_addr", bus.imem_addr, model_pc);
                outstanding = 1;
                out_addr    = model_pc;
                age         = 0;
                dropped     = 0;
                lat         = (force_lat >= 0) ? force_lat : int'($urandom_range(0, 3));
            end else begin
                check("held_req_addr", bus.imem_addr, out_addr);
            end
            if (age >= lat) begin
                ack   = 1'b1;
                rdata = out_addr ^ XOR_KEY;
            end
        end
        bus.imem_ack   = ack;
        bus.imem_rdata = rdata;
        #1;
        check("flush", {31'd0, bus.flush}, {31'd0, p});

        if (r) begin
            model_pc    = RST_PC_A;
            outstanding = 0;
            hold_valid  = 0;
        end else if (p) begin
            if (outstanding) begin
                if (ack) outstanding = 0;
                else     dropped = 1;
            end
            hold_valid = 0;
            model_pc   = {tgt[31:2], 2'b00};
        end else begin
            if (ack) begin
                outstanding = 0;
                if (!dropped) begin
                    it.pc    = out_addr;
                    it.instr = rdata;
                    if (s) begin
                        hold_valid = 1;
                        hold_item  = it;
                    end else begin
                        exp_q.push_back(it);
                    end
                    model_pc = out_addr + 32'd4;
                end
            end else if (hold_valid && !s) begin
                exp_q.push_back(hold_item);
                hold_valid = 0;
            end
        end
        if (!r && outstanding) age++;
        @(posedge clk);
        #1;
    endtask

    // ---------------- scoreboard monitor ----------------
    initial begin : monitor
        logic        c_r, c_s, c_p;
        logic        e_valid;
        logic [31:0] e_pc, e_instr;
        item_t       it;
        e_valid = 1'b0;
        e_pc    = '0;
        e_instr = NOP;
        forever begin
            @(posedge clk);
            c_r = rst;
            c_s = bus.stall;
            c_p = bus.pc_sel;
            #1;
            if (c_r) begin
                e_valid = 1'b0;
                e_pc    = '0;
                e_instr = NOP;
            end else if (c_p) begin
                e_valid = 1'b0;
                e_instr = NOP;
            end else if (!c_s) begin
                if (exp_q.size() > 0) begin
                    it      = exp_q.pop_front();
                    e_valid = 1'b1;
                    e_pc    = it.pc;
                    e_instr = it.instr;
                end else begin
                    e_valid = 1'b0;
                    e_instr = NOP;
                end
            end
            check("if_valid", {31'd0, bus.if_valid}, {31'd0, e_valid});
            check("if_pc",    bus.if_pc,    e_pc);
            check("if_instr", bus.if_instr, e_instr);
        end
    end

    // ---------------- stimulus ----------------
    initial begin : driver
        bit found;
        rst             = 1'b1;
        rst2            = 1'b1;
        bus.stall       = 1'b0;
        bus.pc_sel      = 1'b0;
        bus.alu_target  = '0;
        bus.imem_ack    = 1'b0;
        bus.imem_rdata  = '0;
        bus2.stall      = 1'b0;
        bus2.pc_sel     = 1'b0;
        bus2.alu_target = '0;
        bus2.imem_ack   = 1'b0;
        bus2.imem_rdata = '0;

        // Wrap-around instance: first fetch at 0xFFFF_FFFC, acked immediately.
        @(posedge clk);
        #1;
        rst2 = 1'b0;
        #1;
        check("d2_req",        {31'd0, bus2.imem_req}, 32'd1);
        check("d2_first_addr", bus2.imem_addr, RST_PC_B);
        bus2.imem_ack   = 1'b1;
        bus2.imem_rdata = RST_PC_B ^ XOR_KEY;
        @(posedge clk);
        #1;
        bus2.imem_ack = 1'b0;
        #1;
        check("d2_if_valid", {31'd0, bus2.if_valid}, 32'd1);
        check("d2_if_pc",    bus2.if_pc,    RST_PC_B);
        check("d2_if_instr", bus2.if_instr, RST_PC_B ^ XOR_KEY);
        check("d2_wrap_addr", bus2.imem_addr, 32'h0000_0000);
        check("d2_flush",    {31'd0, bus2.flush}, 32'd0);
        @(posedge clk);
        #1;

        // Reset, then sequential fetch 0,4,8 with a 1-cycle SRAM.
        do_cycle(1, 0, 0, 0);
        do_cycle(1, 0, 0, 0);
        force_lat = 1;
        for (int i = 0; i < 5; i++) do_cycle(0, 0, 0, 0);
        // Stall for 3 cycles while the response for pc=8 returns.
        for (int i = 0; i < 3; i++) do_cycle(0, 1, 0, 0);
        for (int i = 0; i < 3; i++) do_cycle(0, 0, 0, 0);
        // Request to 16 with a 2-cycle SRAM, redirected to 0x103 while pending.
        force_lat = 2;
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 0, 1, 32'h0000_0103);
        do_cycle(0, 0, 0, 0);
        force_lat = 1;
        // Fetch at 0x100 lands under stall, then redirect+stall while in HOLD.
        do_cycle(0, 0, 0, 0);
        do_cycle(0, 1, 0, 0);
        do_cycle(0, 1, 1, 32'h0000_0200);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0);

        // Reset pulse while the request to 40 is outstanding and acked.
        do_cycle(0, 0, 1, 32'd40);
        found = 0;
        for (int i = 0; i < 10; i++) begin
            if (outstanding && !dropped && out_addr == 32'd40 && age >= lat) begin
                found = 1;
                break;
            end
            do_cycle(0, 0, 0, 0);
        end
        check("rst_scenario_reached", {31'd0, found}, 32'd1);
        do_cycle(1, 0, 0, 0);
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0);

        // Randomized traffic.
        force_lat = -1;
        for (int i = 0; i < 3000; i++) begin
            do_cycle(($urandom_range(0, 99) < 2)  ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 25) ? 1'b1 : 1'b0,
                     ($urandom_range(0, 99) < 10) ? 1'b1 : 1'b0,
                     $urandom);
        end
        for (int i = 0; i < 4; i++) do_cycle(0, 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
